// File: rtl/usr_shift_ctrl.sv
// Command sequencer driving a universal shift register's sel/serial_in/parallel_in.
// Define USR_SHIFT_CTRL_ROTATE_EN to enable rotate-right (op 11); otherwise op 11 is rejected.
module usr_shift_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] q_fb,
   output logic [1:0]       sr_sel,
   output logic             sr_serial,
   output logic [WIDTH-1:0] sr_parallel,
   output logic             busy,
   output logic             done,
   output logic             cmd_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_ROR  = 2'b11;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

`ifdef USR_SHIFT_CTRL_ROTATE_EN
   localparam logic ROTATE_EN = 1'b1;
`else
   localparam logic ROTATE_EN = 1'b0;
`endif

   state_t           r_state;
   logic [1:0]       r_op;
   logic             r_fill;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_sel;
   logic [WIDTH-1:0] r_parallel;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_accept;
   logic             w_opRejected;
   logic             w_serial;
   logic             w_unusedQfb;

   assign cmd_ready    = (r_state == IDLE) & rst_n;
   assign w_accept     = cmd_valid & cmd_ready;
   assign w_opRejected = (cmd_op == OP_ROR) & ~ROTATE_EN;
   assign w_unusedQfb  = ^q_fb[WIDTH-1:1];

   // Rotate takes its fill straight from the register output so each step wraps q[0] into the MSB.
   always_comb begin
      w_serial = 1'b0;
      if (r_state == SHIFT) begin
         w_serial = (r_op == OP_ROR) ? q_fb[0] : r_fill;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_op       <= OP_LOAD;
         r_fill     <= 1'b0;
         r_cnt      <= '0;
         r_sel      <= SEL_HOLD;
         r_parallel <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op       <= cmd_op;
                  r_fill     <= cmd_data[0];
                  r_parallel <= cmd_data;
                  r_busy     <= 1'b1;
                  if (cmd_op == OP_LOAD) begin
                     r_state <= LOAD;
                     r_sel   <= SEL_LOAD;
                  end else if (w_opRejected) begin
                     r_state <= FINISH;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else if (cmd_count == '0) begin
                     r_state <= FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= SHIFT;
                     r_cnt   <= cmd_count;
                     r_sel   <= (cmd_op == OP_SHL) ? SEL_SHL : SEL_SHR;
                  end
               end
            end
            LOAD: begin
               r_state <= FINISH;
               r_sel   <= SEL_HOLD;
               r_done  <= 1'b1;
            end
            SHIFT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= FINISH;
                  r_sel   <= SEL_HOLD;
                  r_done  <= 1'b1;
               end
            end
            FINISH: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_sel   <= SEL_HOLD;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   assign sr_sel      = r_sel;
   assign sr_serial   = w_serial;
   assign sr_parallel = r_parallel;
   assign busy        = r_busy;
   assign done        = r_done;
   assign cmd_err     = r_err;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Testbench for usr_shift_ctrl with a behavioural 4-bit universal shift register closing the loop.
// Honours USR_SHIFT_CTRL_ROTATE_EN for the expected rotate results.
module tb_usr_shift_ctrl;

   localparam int WIDTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_count;
   logic [WIDTH-1:0] q_fb;
   logic [1:0]       sr_sel;
   logic             sr_serial;
   logic [WIDTH-1:0] sr_parallel;
   logic             busy;
   logic             done;
   logic             cmd_err;

   logic [WIDTH-1:0] regQ = '0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] op;
      logic [3:0] data;
      logic [2:0] count;
      logic [3:0] expQ;
      int         expLat;
      logic       expErr;
   } vec_t;

   vec_t vecs[12];

   usr_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .cmd_count  (cmd_count),
      .q_fb       (q_fb),
      .sr_sel     (sr_sel),
      .sr_serial  (sr_serial),
      .sr_parallel(sr_parallel),
      .busy       (busy),
      .done       (done),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   // Downstream universal shift register: 00 hold, 01 right (serial into MSB), 10 left, 11 load.
   always @(posedge clk) begin
      case (sr_sel)
         2'b01:   regQ <= {sr_serial, regQ[3:1]};
         2'b10:   regQ <= {regQ[2:0], sr_serial};
         2'b11:   regQ <= sr_parallel;
         default: regQ <= regQ;
      endcase
   end
   assign q_fb = regQ;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Issues one command and waits (bounded) for done; leaves the bench at the negedge where done is seen.
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data, input logic [2:0] count,
                                output int latency, output logic err);
      @(negedge clk);
      checkOutput("ready_before_cmd", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = count;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      latency   = -1;
      err       = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (done) begin
            latency = c;
            err     = cmd_err;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int   lat;
      logic err;
      int   doneSeen;
      int   accIdx[2];
      int   nAcc;

      vecs[0]  = '{2'b00, 4'b0000, 3'd0, 4'b0000, 2, 1'b0};
      vecs[1]  = '{2'b01, 4'b0001, 3'd2, 4'b1100, 3, 1'b0};
      vecs[2]  = '{2'b10, 4'b0000, 3'd3, 4'b0000, 4, 1'b0};
      vecs[3]  = '{2'b10, 4'b0001, 3'd0, 4'b0000, 1, 1'b0};
      vecs[4]  = '{2'b00, 4'b1101, 3'd0, 4'b1101, 2, 1'b0};
`ifdef USR_SHIFT_CTRL_ROTATE_EN
      vecs[5]  = '{2'b11, 4'b0000, 3'd1, 4'b1110, 2, 1'b0};
      vecs[6]  = '{2'b11, 4'b0000, 3'd3, 4'b1101, 4, 1'b0};
      vecs[7]  = '{2'b11, 4'b0000, 3'd0, 4'b1101, 1, 1'b0};
`else
      vecs[5]  = '{2'b11, 4'b0000, 3'd1, 4'b1101, 1, 1'b1};
      vecs[6]  = '{2'b11, 4'b0000, 3'd3, 4'b1101, 1, 1'b1};
      vecs[7]  = '{2'b11, 4'b0000, 3'd0, 4'b1101, 1, 1'b1};
`endif
      vecs[8]  = '{2'b01, 4'b0001, 3'd7, 4'b1111, 8, 1'b0};
      vecs[9]  = '{2'b10, 4'b0000, 3'd5, 4'b0000, 6, 1'b0};
      vecs[10] = '{2'b00, 4'b1010, 3'd0, 4'b1010, 2, 1'b0};
      vecs[11] = '{2'b01, 4'b0000, 3'd1, 4'b0101, 2, 1'b0};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = '0;
      cmd_count = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_sr_sel", int'(sr_sel), 0);
      checkOutput("rst_sr_serial", int'(sr_serial), 0);
      checkOutput("rst_sr_parallel", int'(sr_parallel), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_cmd_err", int'(cmd_err), 0);
      checkOutput("rst_cmd_ready", int'(cmd_ready), 0);
      rst_n = 1'b1;
      #1;
      checkOutput("ready_after_rst", int'(cmd_ready), 1);

      // Load 1100 with per-cycle checks
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_data  = 4'b1100;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("load_sel", int'(sr_sel), 3);
      checkOutput("load_parallel", int'(sr_parallel), 12);
      checkOutput("load_busy", int'(busy), 1);
      checkOutput("load_ready_low", int'(cmd_ready), 0);
      checkOutput("load_done_early", int'(done), 0);
      @(negedge clk);
      checkOutput("load_done", int'(done), 1);
      checkOutput("load_sel_hold", int'(sr_sel), 0);
      checkOutput("load_q", int'(regQ), 12);
      @(negedge clk);
      checkOutput("load_done_pulse", int'(done), 0);
      checkOutput("load_ready_back", int'(cmd_ready), 1);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].op, vecs[i].data, vecs[i].count, lat, err);
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
         checkOutput($sformatf("vec%0d_q", i), int'(regQ), int'(vecs[i].expQ));
         checkOutput($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].expErr));
         @(negedge clk);
         checkOutput($sformatf("vec%0d_done_pulse", i), int'(done), 0);
         checkOutput($sformatf("vec%0d_ready_back", i), int'(cmd_ready), 1);
      end

      // Shift right by 2 from 0000 with fill 1, checking each cycle
      applyStimulus(2'b00, 4'b0000, 3'd0, lat, err);
      checkOutput("clr_q", int'(regQ), 0);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_data  = 4'b0001;
      cmd_count = 3'd2;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("shr_sel_c1", int'(sr_sel), 1);
      checkOutput("shr_serial_c1", int'(sr_serial), 1);
      @(negedge clk);
      checkOutput("shr_sel_c2", int'(sr_sel), 1);
      checkOutput("shr_q_c2", int'(regQ), 8);
      checkOutput("shr_done_c2", int'(done), 0);
      @(negedge clk);
      checkOutput("shr_sel_fin", int'(sr_sel), 0);
      checkOutput("shr_serial_fin", int'(sr_serial), 0);
      checkOutput("shr_done", int'(done), 1);
      checkOutput("shr_q_fin", int'(regQ), 12);

      // Reset during a count-4 shift: one step lands, no done
      applyStimulus(2'b00, 4'b0000, 3'd0, lat, err);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_data  = 4'b0001;
      cmd_count = 3'd4;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst_n     = 1'b0;
      doneSeen  = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) doneSeen = 1;
      end
      checkOutput("abort_no_done", doneSeen, 0);
      checkOutput("abort_q", int'(regQ), 8);
      checkOutput("abort_sel", int'(sr_sel), 0);
      checkOutput("abort_serial", int'(sr_serial), 0);
      checkOutput("abort_parallel", int'(sr_parallel), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_ready_low", int'(cmd_ready), 0);
      rst_n = 1'b1;
      #1;
      checkOutput("abort_ready_back", int'(cmd_ready), 1);
      applyStimulus(2'b00, 4'b0101, 3'd0, lat, err);
      checkOutput("post_abort_lat", lat, 2);
      checkOutput("post_abort_q", int'(regQ), 5);

      // Back-to-back loads with cmd_valid held high
      @(negedge clk);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_data  = 4'b0011;
      nAcc      = 0;
      doneSeen  = 0;
      accIdx[0] = -1;
      accIdx[1] = -1;
      for (int k = 0; k < 10; k++) begin
         if (nAcc == 1) cmd_data = 4'b1010;
         if (nAcc == 2) cmd_valid = 1'b0;
         if (done) doneSeen++;
         if (cmd_ready && cmd_valid && nAcc < 2) begin
            accIdx[nAcc] = k;
            nAcc++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      checkOutput("b2b_accepts", nAcc, 2);
      checkOutput("b2b_gap", accIdx[1] - accIdx[0], 3);
      checkOutput("b2b_done_count", doneSeen, 2);
      checkOutput("b2b_q", int'(regQ), 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
